// File: rtl/mem_ctrl.sv
// Memory access controller: owns MAR/MDR and runs a four-phase req/ack access to external memory.
// Optional MEM_TIMEOUT_EN forces completion of an unacknowledged request and sets a sticky mem_err.
module mem_ctrl #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Buss,
  input  logic        ldMAR,
  input  logic        ldMDR,
  input  logic        selMDR,
  input  logic        memEN,
  input  logic        memWE,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic        R,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_mar;
  logic [15:0] r_mdr;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_we;
  logic        r_req;
  logic        r_ready;
  logic [15:0] r_rdata_q;
  logic        r_err;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{ERR_DATA, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_req     <= 1'b0;
      r_ready   <= 1'b0;
      r_rdata_q <= '0;
      r_err     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      // Register loads are independent of the access FSM; the access works off its snapshot.
      if (ldMAR) r_mar <= Buss;
      if (ldMDR) r_mdr <= selMDR ? r_rdata_q : Buss;

      case (r_state)
        S_IDLE: begin
          if (memEN) begin
            r_addr  <= r_mar;
            r_wdata <= r_mdr;
            r_we    <= memWE;
            r_req   <= 1'b1;
            r_state <= S_REQ;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_req   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_DONE;
            if (!r_we) r_rdata_q <= mem_rdata;
`ifdef MEM_TIMEOUT_EN
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
            if (!r_we) r_rdata_q <= ERR_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        S_DONE: begin
          // Four-phase: no new access until the requester drops memEN.
          if (!memEN) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign MAR       = r_mar;
  assign MDR       = r_mdr;
  assign R         = r_ready;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_req   = r_req;
  assign mem_err   = r_err;

endmodule
